// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one memory burst port,
// moving each 256-bit line as four 64-bit beats.
module cache_arbiter #(
   parameter int LINE_W = 256,
   parameter int BEAT_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [31:0]       i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [31:0]       d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [31:0]       mem_addr,
   output logic [BEAT_W-1:0] mem_wdata,
   input  logic [BEAT_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   localparam int NBEATS = LINE_W / BEAT_W;
   localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] I_RD = 3'd1;
   localparam logic [2:0] D_RD = 3'd2;
   localparam logic [2:0] D_WR = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   // last_grant: 0 = I-cache served last, 1 = D-cache served last
   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic [LINE_W-1:0] rline_q, rline_d;
   logic [LINE_W-1:0] wline_q, wline_d;
   logic              last_grant_q, last_grant_d;
   logic              d_req;
   logic              burst;

   assign d_req = d_read | d_write;

   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      addr_d       = addr_q;
      rline_d      = rline_q;
      wline_d      = wline_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            // On a tie, D wins unless it was the side served last
            if (d_req && (!i_read || !last_grant_q)) begin
               state_d      = d_write ? D_WR : D_RD;
               addr_d       = d_addr & ~32'h1F;
               beat_cnt_d   = '0;
               last_grant_d = 1'b1;
               if (d_write) begin
                  wline_d = d_wdata;
               end
            end else if (i_read) begin
               state_d      = I_RD;
               addr_d       = i_addr & ~32'h1F;
               beat_cnt_d   = '0;
               last_grant_d = 1'b0;
            end
         end
         I_RD, D_RD: begin
            if (mem_resp) begin
               rline_d[BEAT_W*beat_cnt_q +: BEAT_W] = mem_rdata;
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d = DONE;
               end
            end
         end
         D_WR: begin
            if (mem_resp) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         beat_cnt_q   <= '0;
         addr_q       <= '0;
         rline_q      <= '0;
         wline_q      <= '0;
         last_grant_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         addr_q       <= addr_d;
         rline_q      <= rline_d;
         wline_q      <= wline_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Every output decodes registered state only, so nothing from the inputs reaches mem_*
   assign burst     = (state_q == I_RD) || (state_q == D_RD) || (state_q == D_WR);
   assign mem_read  = (state_q == I_RD) || (state_q == D_RD);
   assign mem_write = (state_q == D_WR);
   assign mem_addr  = burst ? addr_q : 32'h0;
   assign mem_wdata = mem_write ? wline_q[BEAT_W*beat_cnt_q +: BEAT_W] : '0;
   assign i_resp    = (state_q == DONE) && !last_grant_q;
   assign d_resp    = (state_q == DONE) && last_grant_q;
   assign i_rdata   = rline_q;
   assign d_rdata   = rline_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a table of single-requester bursts against a
// simple memory responder, plus hand-written tie, reset and drop sequences.
module tb_cache_arbiter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_read = 1'b0;
   logic [31:0]  i_addr = '0;
   logic [255:0] i_rdata;
   logic         i_resp;
   logic         d_read = 1'b0;
   logic         d_write = 1'b0;
   logic [31:0]  d_addr = '0;
   logic [255:0] d_wdata = '0;
   logic [255:0] d_rdata;
   logic         d_resp;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_addr;
   logic [63:0]  mem_wdata;
   logic [63:0]  mem_rdata = '0;
   logic         mem_resp = 1'b0;

   int n_checks = 0;
   int n_fail = 0;

   // Responder configuration, set by the stimulus code
   int           mem_waits = 0;
   logic [255:0] mem_line = '0;
   logic [255:0] exp_wline = '0;
   int           beat_idx = 0;
   int           wait_cnt = 0;

   typedef struct {
      logic         is_d;
      logic         wr;
      logic         both;
      logic [31:0]  addr;
      logic [255:0] line;
      int           waits;
      int           drop_at;
      logic [31:0]  exp_addr;
   } vec_t;

   localparam int N_VEC = 6;
   vec_t vecs[N_VEC];

   cache_arbiter #(.LINE_W(256), .BEAT_W(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory model: each beat is offered after mem_waits idle cycles; write beats must be held
   always @(negedge clk) begin
      if (mem_read || mem_write) begin
         if (mem_write) begin
            check($sformatf("wdata_beat%0d", beat_idx), mem_wdata, exp_wline[64*(beat_idx & 3) +: 64]);
         end
         if (wait_cnt == mem_waits) begin
            mem_resp  = 1'b1;
            mem_rdata = mem_line[64*(beat_idx & 3) +: 64];
            beat_idx  = beat_idx + 1;
            wait_cnt  = 0;
         end else begin
            mem_resp = 1'b0;
            wait_cnt = wait_cnt + 1;
         end
      end else begin
         mem_resp = 1'b0;
         beat_idx = 0;
         wait_cnt = 0;
      end
   end

   task automatic drop_requests();
      i_read  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
   endtask

   task automatic apply_stimulus(input vec_t v, input string tag);
      int cyc;
      int burst_cyc;
      bit got;
      mem_waits = v.waits;
      mem_line  = v.wr ? 256'h0 : v.line;
      exp_wline = v.wr ? v.line : 256'h0;
      @(negedge clk);
      if (v.is_d) begin
         d_addr  = v.addr;
         d_write = v.wr;
         d_read  = !v.wr || v.both;
         d_wdata = v.wr ? v.line : 256'h0;
      end else begin
         i_addr = v.addr;
         i_read = 1'b1;
      end
      cyc = 0;
      burst_cyc = 0;
      got = 1'b0;
      while (!got && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (mem_read || mem_write) begin
            burst_cyc++;
            check({tag, "_mem_addr"}, mem_addr, v.exp_addr);
            check({tag, "_rw_dir"}, {mem_read, mem_write}, v.wr ? 2'b01 : 2'b10);
         end
         if (i_resp || d_resp) begin
            got = 1'b1;
         end else if (v.drop_at != 0 && cyc == v.drop_at) begin
            drop_requests();
         end
      end
      check({tag, "_timeout"}, !got, 1'b0);
      check({tag, "_i_resp"}, i_resp, !v.is_d);
      check({tag, "_d_resp"}, d_resp, v.is_d);
      // The requester samples resp at the edge after the one that entered DONE
      check({tag, "_latency"}, cyc + 1, 4 * (v.waits + 1) + 2);
      check({tag, "_burst_cycles"}, burst_cyc, 4 * (v.waits + 1));
      if (!v.wr) begin
         check({tag, "_i_rdata"}, i_rdata, v.line);
         check({tag, "_d_rdata"}, d_rdata, v.line);
      end
      drop_requests();
      @(negedge clk);
      check({tag, "_resp_single"}, {i_resp, d_resp}, 2'b00);
      check({tag, "_idle_after"}, {mem_read, mem_write, mem_addr}, 34'h0);
      @(negedge clk);
   endtask

   task automatic check_output_reset(input string tag);
      check({tag, "_mem_rw"}, {mem_read, mem_write}, 2'b00);
      check({tag, "_mem_addr"}, mem_addr, 32'h0);
      check({tag, "_mem_wdata"}, mem_wdata, 64'h0);
      check({tag, "_resps"}, {i_resp, d_resp}, 2'b00);
      check({tag, "_i_rdata"}, i_rdata, 256'h0);
      check({tag, "_d_rdata"}, d_rdata, 256'h0);
   endtask

   task automatic tie_sequence();
      int cyc;
      int first_rd;
      bit got;
      logic [31:0] seen_addr;
      logic exp_d;
      mem_waits = 0;
      mem_line  = {64'hA4A4_0000_0000_0004, 64'hA3A3_0000_0000_0003,
                   64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001};
      @(negedge clk);
      i_addr = 32'h0000_0100;
      d_addr = 32'h0000_0200;
      i_read = 1'b1;
      d_read = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_d = (k != 1);
         cyc = 0;
         first_rd = -1;
         got = 1'b0;
         seen_addr = '0;
         while (!got && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (mem_read && first_rd < 0) begin
               first_rd  = cyc;
               seen_addr = mem_addr;
            end
            if (i_resp || d_resp) got = 1'b1;
         end
         check($sformatf("tie%0d_timeout", k), !got, 1'b0);
         check($sformatf("tie%0d_grant_delay", k), first_rd, 1);
         check($sformatf("tie%0d_addr", k), seen_addr, exp_d ? 32'h0000_0200 : 32'h0000_0100);
         check($sformatf("tie%0d_d_resp", k), d_resp, exp_d);
         check($sformatf("tie%0d_i_resp", k), i_resp, !exp_d);
         check($sformatf("tie%0d_d_rdata", k), d_rdata, mem_line);
         if (k < 2) begin
            @(negedge clk);
            check($sformatf("tie%0d_idle_gap", k), {mem_read, mem_write}, 2'b00);
         end
      end
      drop_requests();
      repeat (2) @(negedge clk);
   endtask

   task automatic reset_mid_burst();
      vec_t fresh;
      mem_waits = 0;
      mem_line  = {64'hBEEF_0000_0000_0004, 64'hBEEF_0000_0000_0003,
                   64'hBEEF_0000_0000_0002, 64'hBEEF_0000_0000_0001};
      @(negedge clk);
      i_addr = 32'h0000_3000;
      i_read = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_pre_busy", mem_read, 1'b1);
      #2;
      rst_n  = 1'b0;
      i_read = 1'b0;
      #1;
      check_output_reset("rst_async");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_no_resp", {i_resp, d_resp, mem_read, mem_write}, 4'b0000);
      fresh = '{is_d: 1'b0, wr: 1'b0, both: 1'b0, addr: 32'h0000_3004,
                line: {64'hC0DE_0000_0000_0044, 64'hC0DE_0000_0000_0033,
                       64'hC0DE_0000_0000_0022, 64'hC0DE_0000_0000_0011},
                waits: 0, drop_at: 0, exp_addr: 32'h0000_3000};
      apply_stimulus(fresh, "post_rst");
   endtask

   initial begin
      vecs[0] = '{is_d: 1'b0, wr: 1'b0, both: 1'b0, addr: 32'h0000_1234,
                  line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                  waits: 0, drop_at: 0, exp_addr: 32'h0000_1220};
      vecs[1] = '{is_d: 1'b1, wr: 1'b1, both: 1'b0, addr: 32'hABCD_EF7F,
                  line: {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
                         64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000},
                  waits: 2, drop_at: 0, exp_addr: 32'hABCD_EF60};
      vecs[2] = '{is_d: 1'b1, wr: 1'b0, both: 1'b0, addr: 32'h8000_001F,
                  line: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                         64'h5555_AAAA_5555_AAAA, 64'hAAAA_5555_AAAA_5555},
                  waits: 1, drop_at: 0, exp_addr: 32'h8000_0000};
      vecs[3] = '{is_d: 1'b0, wr: 1'b0, both: 1'b0, addr: 32'hFFFF_FFFF,
                  line: {64'hFFFF_0000_FFFF_0003, 64'hFFFF_0000_FFFF_0002,
                         64'hFFFF_0000_FFFF_0001, 64'hFFFF_0000_FFFF_0000},
                  waits: 3, drop_at: 0, exp_addr: 32'hFFFF_FFE0};
      vecs[4] = '{is_d: 1'b1, wr: 1'b1, both: 1'b1, addr: 32'h0000_0040,
                  line: {64'h7777_0000_0000_0004, 64'h6666_0000_0000_0003,
                         64'h5555_0000_0000_0002, 64'h4444_0000_0000_0001},
                  waits: 0, drop_at: 0, exp_addr: 32'h0000_0040};
      vecs[5] = '{is_d: 1'b0, wr: 1'b0, both: 1'b0, addr: 32'h0000_5A5A,
                  line: {64'h9999_0000_0000_0004, 64'h8888_0000_0000_0003,
                         64'h7777_0000_0000_0002, 64'h6666_0000_0000_0001},
                  waits: 0, drop_at: 2, exp_addr: 32'h0000_5A40};

      repeat (2) @(negedge clk);
      check_output_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      tie_sequence();

      for (int i = 0; i < N_VEC; i++) begin
         apply_stimulus(vecs[i], $sformatf("v%0d", i));
      end

      reset_mid_burst();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
